count_to_temperature_horner: RTL



---
 rtl/count_to_temperature_horner.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/count_to_temperature_horner.sv
`timescale 1ns/1ps
// count_to_temperature_horner: converts a raw pulse-duration count into a signed
// temperature in degrees C. It evaluates a cubic polynomial by Horner's method with
// one shared multiplier. The coefficients and the accumulator are Q.FRAC_W fixed point.
// Define TEMP_RANGE_CHECK_EN to reject counts below CNT_MIN; such counts return out_err=1.
module count_to_temperature_horner #(
    parameter int unsigned CNT_W   = 13,
    parameter int unsigned OUT_W   = 9,
    parameter int unsigned FRAC_W  = 30,
    parameter int unsigned ACC_W   = 48,
    parameter logic signed [ACC_W-1:0] C3 = -48'sd508,
    parameter logic signed [ACC_W-1:0] C2 = 48'sd2152253,
    parameter logic signed [ACC_W-1:0] C1 = -48'sd2655871908,
    parameter logic signed [ACC_W-1:0] C0 = 48'sd909641908990,
    parameter int unsigned CNT_MIN = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CNT_W-1:0]        count_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] temp_out,
    output logic                    out_sat,
    output logic                    out_err
);

    localparam int unsigned P_W = ACC_W + CNT_W + 1;  // product width
    localparam int unsigned S_W = P_W + 1;            // product + coefficient
    localparam int unsigned R_W = ACC_W + 1;          // rounding adder width

`ifdef TEMP_RANGE_CHECK_EN
    localparam bit RangeChkEn = 1'b1;
`else
    localparam bit RangeChkEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntMin = CNT_MIN[CNT_W-1:0];

    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [S_W-1:0] AccMaxExt = {{(S_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] AccMinExt = {{(S_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [R_W-1:0] Half =
        {{(ACC_W-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OutMax = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OutMin = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [R_W-1:0] OutMaxExt = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] OutMinExt = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StRound, StDone} state_e;

    state_e                    state_q, state_d;
    logic signed [CNT_W:0]     x_q, x_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]                step_q, step_d;
    logic                      ovf_q, ovf_d;
    logic signed [OUT_W-1:0]   temp_q, temp_d;
    logic                      sat_q, sat_d;
    logic                      err_q, err_d;
    logic                      valid_q, valid_d;

    logic signed [P_W-1:0]     acc_ext, x_ext, prod;
    logic signed [S_W-1:0]     prod_ext, coef_ext, sum;
    logic signed [ACC_W-1:0]   coef, mac_acc;
    logic                      mac_ovf;
    logic signed [R_W-1:0]     rnd, r_full;
    logic signed [OUT_W-1:0]   rnd_temp;
    logic                      rnd_sat;

    // Horner step and final rounding. x is an integer count, so acc*x stays in
    // Q.FRAC_W and adds directly to the next coefficient.
    always_comb begin
        acc_ext  = {{(P_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        x_ext    = {{(P_W-CNT_W-1){x_q[CNT_W]}}, x_q};
        prod     = acc_ext * x_ext;
        case (step_q)
            2'd0:    coef = C2;
            2'd1:    coef = C1;
            default: coef = C0;
        endcase
        prod_ext = {prod[P_W-1], prod};
        coef_ext = {{(S_W-ACC_W){coef[ACC_W-1]}}, coef};
        sum      = prod_ext + coef_ext;
        mac_ovf  = 1'b0;
        mac_acc  = sum[ACC_W-1:0];
        if (sum > AccMaxExt) begin
            mac_acc = AccMax;
            mac_ovf = 1'b1;
        end else if (sum < AccMinExt) begin
            mac_acc = AccMin;
            mac_ovf = 1'b1;
        end

        // Round half up, then clamp to the signed output range.
        rnd      = {acc_q[ACC_W-1], acc_q} + Half;
        r_full   = rnd >>> FRAC_W;
        rnd_sat  = 1'b0;
        rnd_temp = r_full[OUT_W-1:0];
        if (r_full > OutMaxExt) begin
            rnd_temp = OutMax;
            rnd_sat  = 1'b1;
        end else if (r_full < OutMinExt) begin
            rnd_temp = OutMin;
            rnd_sat  = 1'b1;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        acc_d    = acc_q;
        step_d   = step_q;
        ovf_d    = ovf_q;
        temp_d   = temp_q;
        sat_d    = sat_q;
        err_d    = err_q;
        valid_d  = valid_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (RangeChkEn && (count_in < CntMin)) begin
                        // Stuck or no-pulse count: report it without converting.
                        temp_d  = '0;
                        sat_d   = 1'b0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        x_d     = {1'b0, count_in};
                        acc_d   = C3;
                        step_d  = 2'd0;
                        ovf_d   = 1'b0;
                        state_d = StMac;
                    end
                end
            end
            StMac: begin
                acc_d  = mac_acc;
                ovf_d  = ovf_q | mac_ovf;
                step_d = step_q + 2'd1;
                if (step_q == 2'd2) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                temp_d  = rnd_temp;
                sat_d   = rnd_sat | ovf_q;
                err_d   = 1'b0;
                valid_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            ovf_q   <= 1'b0;
            temp_q  <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
            temp_q  <= temp_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign temp_out  = temp_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

endmodule
